countdown_hours_bcd: RTL and testbench

COUNTDOWN_HOURS_BCD -- requirements
Module: countdown_hours_bcd

---
 rtl/hours_pkg.sv | 26 ++
 rtl/bcd_digit_dec.sv | 25 ++
 rtl/countdown_hours_bcd.sv | 104 ++++++++++
 tb/tb_countdown_hours_bcd.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hours_pkg.sv
// Shared definitions for the BCD hours counter: digit type, range limits
// for 24h and 12h modes, and BCD legality helpers.
package hours_pkg;

    typedef logic [3:0] bcd_t;

    // Packed {tens, ones} limits
    localparam logic [7:0] H24_MIN = 8'h00;
    localparam logic [7:0] H24_MAX = 8'h23;
    localparam logic [7:0] H12_MIN = 8'h01;
    localparam logic [7:0] H12_MAX = 8'h12;

    // A single digit is legal BCD when it is 0..9
    function automatic logic bcd_ok(input bcd_t d);
        return (d <= 4'd9);
    endfunction

    // Two legal BCD digits compare numerically when packed, so the range
    // check works directly on {tens, ones}
    function automatic logic hours_ok(input bcd_t tens, input bcd_t ones,
                                      input logic [7:0] lo, input logic [7:0] hi);
        return bcd_ok(tens) && bcd_ok(ones) &&
               ({tens, ones} >= lo) && ({tens, ones} <= hi);
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement: 0 wraps to 9 and raises borrow_o.
module bcd_digit_dec
    import hours_pkg::*;
(
    input  bcd_t digit_i,
    input  logic dec_i,
    output bcd_t digit_o,
    output logic borrow_o
);

    // Combinational decrement with borrow-out on the 0 -> 9 wrap
    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (dec_i) begin
            if (digit_i == 4'd0) begin
                digit_o  = 4'd9;
                borrow_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_hours_bcd.sv
// Two-digit BCD hours down-counter with load, borrow and load-error pulses.
// Default build counts 23..00; defining HOURS_12H_EN selects 12..01.
module countdown_hours_bcd
    import hours_pkg::*;
#(
    parameter int unsigned STOP_AT_MIN = 0
) (
    input  logic       clkinput,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_first,
    input  logic [3:0] load_second,
    output logic [3:0] first,
    output logic [3:0] second,
    output logic       borrow,
    output logic       at_min,
    output logic       load_err
);

`ifdef HOURS_12H_EN
    localparam logic [7:0] MIN_VAL = H12_MIN;
    localparam logic [7:0] MAX_VAL = H12_MAX;
    localparam logic [7:0] RST_VAL = H12_MAX;
`else
    localparam logic [7:0] MIN_VAL = H24_MIN;
    localparam logic [7:0] MAX_VAL = H24_MAX;
    localparam logic [7:0] RST_VAL = H24_MIN;
`endif

    bcd_t ones_q, ones_d, tens_q, tens_d;
    logic borrow_q, borrow_d, err_q, err_d;
    bcd_t ones_dec, tens_dec;
    logic ones_brw, tens_brw;
    logic min_hit, load_ok;

    // Ones digit always offers its decremented value; tens follows its borrow
    bcd_digit_dec u_ones (
        .digit_i  (ones_q),
        .dec_i    (1'b1),
        .digit_o  (ones_dec),
        .borrow_o (ones_brw)
    );

    bcd_digit_dec u_tens (
        .digit_i  (tens_q),
        .dec_i    (ones_brw),
        .digit_o  (tens_dec),
        .borrow_o (tens_brw)
    );

    assign min_hit = ({tens_q, ones_q} == MIN_VAL);
    assign load_ok = hours_ok(load_second, load_first, MIN_VAL, MAX_VAL);

    // Next-state: load beats tick; at minimum either wrap to max or hold.
    // tens_brw guards against ever stepping below 00.
    always_comb begin
        ones_d   = ones_q;
        tens_d   = tens_q;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        if (load) begin
            if (load_ok) begin
                tens_d = load_second;
                ones_d = load_first;
            end else begin
                err_d = 1'b1;
            end
        end else if (tick) begin
            if (min_hit) begin
                if (STOP_AT_MIN == 0) begin
                    tens_d   = MAX_VAL[7:4];
                    ones_d   = MAX_VAL[3:0];
                    borrow_d = 1'b1;
                end
            end else if (!tens_brw) begin
                tens_d = tens_dec;
                ones_d = ones_dec;
            end
        end
    end

    // Count and pulse registers, asynchronously reset
    always_ff @(posedge clkinput or posedge reset) begin
        if (reset) begin
            tens_q   <= RST_VAL[7:4];
            ones_q   <= RST_VAL[3:0];
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    assign first    = ones_q;
    assign second   = tens_q;
    assign borrow   = borrow_q;
    assign load_err = err_q;
    assign at_min   = min_hit;

endmodule

// File: tb/tb_countdown_hours_bcd.sv
// Scoreboard bench for countdown_hours_bcd: instance 0 wraps, instance 1
// saturates at minimum. Honours HOURS_12H_EN for expected range.
module tb_countdown_hours_bcd;

`ifdef HOURS_12H_EN
    localparam int MINV = 1;
    localparam int MAXV = 12;
    localparam int RSTV = 12;
`else
    localparam int MINV = 0;
    localparam int MAXV = 23;
    localparam int RSTV = 0;
`endif

    logic       clkinput = 1'b0;
    logic       reset, tick, load;
    logic [3:0] load_first, load_second;
    logic [3:0] first0, second0, first1, second1;
    logic       borrow0, at_min0, load_err0, borrow1, at_min1, load_err1;

    countdown_hours_bcd #(.STOP_AT_MIN(0)) dut_wrap (
        .clkinput(clkinput), .reset(reset), .tick(tick), .load(load),
        .load_first(load_first), .load_second(load_second),
        .first(first0), .second(second0), .borrow(borrow0),
        .at_min(at_min0), .load_err(load_err0)
    );

    countdown_hours_bcd #(.STOP_AT_MIN(1)) dut_stop (
        .clkinput(clkinput), .reset(reset), .tick(tick), .load(load),
        .load_first(load_first), .load_second(load_second),
        .first(first1), .second(second1), .borrow(borrow1),
        .at_min(at_min1), .load_err(load_err1)
    );

    always #5 clkinput = ~clkinput;

    typedef struct {
        string      tag;
        int         dut;
        logic [3:0] f;
        logic [3:0] s;
        logic       b;
        logic       m;
        logic       e;
    } exp_t;

    exp_t sbq[$];
    int   mval[2];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expected post-state of one model as a scoreboard entry
    task automatic push_exp(input string tag, input int d, input logic b, input logic e);
        exp_t x;
        x.tag = tag;
        x.dut = d;
        x.f   = 4'(mval[d] % 10);
        x.s   = 4'(mval[d] / 10);
        x.b   = b;
        x.m   = (mval[d] == MINV);
        x.e   = e;
        sbq.push_back(x);
    endtask

    // Integer-valued reference for one clock edge
    task automatic model_step(input string tag, input int d, input logic ld,
                              input logic [3:0] lf, input logic [3:0] ls, input logic tk);
        int   v;
        logic b, e;
        b = 1'b0;
        e = 1'b0;
        v = int'(ls) * 10 + int'(lf);
        if (ld) begin
            if (lf <= 4'd9 && ls <= 4'd9 && v >= MINV && v <= MAXV) mval[d] = v;
            else e = 1'b1;
        end else if (tk) begin
            if (mval[d] == MINV) begin
                if (d == 0) begin
                    mval[d] = MAXV;
                    b = 1'b1;
                end
            end else begin
                mval[d] = mval[d] - 1;
            end
        end
        push_exp(tag, d, b, e);
    endtask

    task automatic drain();
        exp_t x;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            if (x.dut == 0) begin
                chk({x.tag, "/w/first"},  first0,  x.f);
                chk({x.tag, "/w/second"}, second0, x.s);
                chk({x.tag, "/w/borrow"}, {3'b0, borrow0},   {3'b0, x.b});
                chk({x.tag, "/w/at_min"}, {3'b0, at_min0},   {3'b0, x.m});
                chk({x.tag, "/w/lderr"},  {3'b0, load_err0}, {3'b0, x.e});
            end else begin
                chk({x.tag, "/s/first"},  first1,  x.f);
                chk({x.tag, "/s/second"}, second1, x.s);
                chk({x.tag, "/s/borrow"}, {3'b0, borrow1},   {3'b0, x.b});
                chk({x.tag, "/s/at_min"}, {3'b0, at_min1},   {3'b0, x.m});
                chk({x.tag, "/s/lderr"},  {3'b0, load_err1}, {3'b0, x.e});
            end
        end
    endtask

    task automatic step(input string tag, input logic ld, input logic [3:0] lf,
                        input logic [3:0] ls, input logic tk);
        @(negedge clkinput);
        load = ld; load_first = lf; load_second = ls; tick = tk;
        model_step(tag, 0, ld, lf, ls, tk);
        model_step(tag, 1, ld, lf, ls, tk);
        @(posedge clkinput);
        #1;
        drain();
    endtask

    task automatic reset_models(input string tag);
        mval[0] = RSTV;
        mval[1] = RSTV;
        push_exp(tag, 0, 1'b0, 1'b0);
        push_exp(tag, 1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; load = 1'b0;
        load_first = '0; load_second = '0;
        #1;
        reset_models("reset");
        drain();
        @(negedge clkinput);
        reset = 1'b0;

        // Full cycle of the range from reset value, including the wrap
        for (int i = 0; i < 24; i++) step($sformatf("tick%0d", i), 1'b0, 4'd0, 4'd0, 1'b1);

        // Tens borrow path
        step("load20", 1'b1, 4'd0, 4'd2, 1'b0);
        step("tick20", 1'b0, 4'd0, 4'd0, 1'b1);
        step("load10", 1'b1, 4'd0, 4'd1, 1'b0);
        step("tick10", 1'b0, 4'd0, 4'd0, 1'b1);

        // Illegal loads leave the count alone
        step("load25", 1'b1, 4'd5, 4'd2, 1'b0);
        step("idle_a", 1'b0, 4'd0, 4'd0, 1'b0);
        step("load9_10", 1'b1, 4'd10, 4'd9, 1'b0);
        step("load00", 1'b1, 4'd0, 4'd0, 1'b0);
        step("load13", 1'b1, 4'd3, 4'd1, 1'b0);
        step("loadA", 1'b1, 4'd0, 4'd10, 1'b0);

        // Load wins over a simultaneous tick
        step("load15tk", 1'b1, 4'd5, 4'd1, 1'b1);
        step("idle_b", 1'b0, 4'd0, 4'd0, 1'b0);

        // Minimum boundary: 01 -> min, then ticks at minimum
        step("load01", 1'b1, 4'd1, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) step($sformatf("mintick%0d", i), 1'b0, 4'd0, 4'd0, 1'b1);

        // Asynchronous reset landing mid-cycle with a tick pending at 17
        step("load17", 1'b1, 4'd7, 4'd1, 1'b0);
        @(negedge clkinput);
        load = 1'b0; tick = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        reset_models("async_rst");
        drain();
        @(negedge clkinput);
        reset = 1'b0; tick = 1'b0;
        step("post_rst", 1'b0, 4'd0, 4'd0, 1'b1);
        step("post_rst2", 1'b0, 4'd0, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
